step_tick_ctrl: RTL and testbench
=================================

Name: step_tick_ctrl

Overview:
- Programmable tick scheduler for the Enigma rotor-step and display timing path.
- Divides clkin by a runtime-configurable period and emits one-cycle tick strobes plus a 50% square wave (clkout).
- Sequencing modes: free-run, single-step, counted burst.
- Shadow-register config handshake; new periods take effect only on tick boundaries, so no short or glitched periods occur.

Parameters:
- DIV_W, 32: width of the period and divide counter.
- DEFAULT_PERIOD, 5000: period loaded at reset; clkin cycles per half-period of clkout.
- BURST_W, 8: width of the burst length.

Ports:
- clkin, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous active-high reset.
- cfg_period, input, DIV_W: requested half-period in clkin cycles.
- cfg_valid, input, 1: config request.
- cfg_ready, output, 1: config slot free.
- run, input, 1: level; free-run while high.
- step_req, input, 1: pulse; request exactly one tick.
- burst_start, input, 1: pulse; request burst_len ticks.
- burst_len, input, BURST_W: tick count for a burst; sampled on burst_start.
- busy, output, 1: high in any state except IDLE.
- tick, output, 1: one-cycle strobe at each period expiry.
- clkout, output, 1: toggles on every tick.
- tick_count, output, 16: tick counter (see Optional Feature).

Behaviour:
- Reset, asynchronous, applied immediately:
  - state=IDLE, counter=1, period=DEFAULT_PERIOD, no config pending.
  - tick=0, clkout=0, busy=0, cfg_ready=1, tick_count=0.
  - Reset mid-burst or mid-run discards all progress.
- Divide counter:
  - Counts 1..period only in RUN/STEP/BURST; held at 1 in IDLE.
  - When counter==period: tick=1 for that cycle (registered, visible the following cycle), clkout toggles, counter=1.
  - First tick comes period cycles after leaving IDLE.
  - period==1 gives a tick every cycle.
- FSM states: IDLE, RUN, STEP, BURST. Priority when requests coincide in IDLE: run > burst_start > step_req.
  - IDLE->RUN: run==1.
  - IDLE->BURST: burst_start with burst_len!=0; remaining=burst_len. burst_len==0 is a no-op and stays IDLE.
  - IDLE->STEP: step_req.
  - RUN->IDLE: on the first tick at which run==0. The current period completes and its tick is emitted; no truncated period.
  - STEP->IDLE: after its single tick.
  - BURST->IDLE: on the tick that decrements remaining to 0.
- Requests arriving outside IDLE are ignored (step_req, burst_start) or sampled at the next tick (run).
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_period==0 is clamped to 1.
  - In IDLE the value loads into period on the next edge.
  - Otherwise it goes to a shadow register: cfg_ready drops to 0; the shadow copies into period on the next tick, where counter resets to 1 under the new period; cfg_ready returns to 1 the cycle after.
  - A config accepted in the same cycle as a tick applies at the following tick.
- Width rules:
  - counter and period are DIV_W unsigned; comparison is equality only.
  - remaining is BURST_W wide.
  - tick_count wraps modulo 2^16.

Optional Feature:
- Macro: STEP_TICK_CTRL_TICK_COUNT_EN.
- Defined: tick_count increments on every tick and wraps 0xFFFF->0x0000; it is cleared by rst only.
- Undefined: tick_count is tied to 0 and no counter register is synthesised. Port list unchanged.

Decomposition:
- Shared package (enigma_pkg):
  - FSM state enum, 2 bits: IDLE/RUN/STEP/BURST.
  - DEFAULT_PERIOD constant.
  - Type tick_count_t (16 bits).
- One natural sub-module, tick_divider: period-input divide counter with tick and clkout outputs and a count-enable.
- Top: FSM, shadow config and burst counter.

Test Plan:
- Reset mid-RUN: cfg_period=4 accepted, run=1, assert rst after 2 ticks -> outputs zero asynchronously; period=5000 restored; state IDLE.
- Free-run: cfg_period=3 in IDLE, run=1 -> tick every 3 cycles, first tick 3 cycles after entry; clkout period 6 cycles. Drop run mid-period -> one more tick, then busy=0.
- Burst: period=2, burst_len=5 -> exactly 5 ticks 2 cycles apart, then IDLE. burst_len=0 -> no tick, busy stays 0.
- Priority: run, burst_start and step_req asserted in the same IDLE cycle -> RUN entered; burst and step ignored.
- Live reconfig: RUN with period=4, cfg_period=2 accepted mid-period -> cfg_ready=0 until the next tick; that tick still at 4 cycles, later ticks every 2 cycles. cfg_period=0 -> tick every cycle.
- With STEP_TICK_CTRL_TICK_COUNT_EN: 65537 ticks at period=1 -> tick_count=1. Without the macro -> tick_count stays 0.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor-step / display tick scheduler.
package enigma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BURST = 2'd3
   } state_t;

   localparam int DEFAULT_PERIOD = 5000;

   typedef logic [15:0] tick_count_t;

endpackage

// File: rtl/step_tick_ctrl_if.sv
// Period configuration handshake between a config master and the tick scheduler.
interface step_tick_ctrl_if #(
   parameter int DIV_W = 32
);
   logic [DIV_W-1:0] cfg_period;
   logic             cfg_valid;
   logic             cfg_ready;

   modport master (output cfg_period, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_period, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/tick_divider.sv
// Divide counter: counts 1..period while enabled, strobes tick and toggles clkout on expiry.
module tick_divider #(
   parameter int DIV_W = 32
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] period,
   output logic             expire,
   output logic             tick,
   output logic             clkout
);

   logic [DIV_W-1:0] counter_reg;
   logic             tick_reg;
   logic             clkout_reg;

   // Expiry is combinational so the controller can act on the same edge the tick is registered.
   assign expire = en && (counter_reg == period);

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         counter_reg <= DIV_W'(1);
         tick_reg    <= 1'b0;
         clkout_reg  <= 1'b0;
      end else begin
         tick_reg <= expire;
         if (expire) begin
            counter_reg <= DIV_W'(1);
            clkout_reg  <= ~clkout_reg;
         end else if (en) begin
            counter_reg <= counter_reg + DIV_W'(1);
         end else begin
            counter_reg <= DIV_W'(1);
         end
      end
   end

   assign tick   = tick_reg;
   assign clkout = clkout_reg;

endmodule

// File: rtl/step_tick_ctrl.sv
// Tick scheduler top: sequencing FSM, shadowed period config and burst counter.
// Optional tick counter enabled by defining STEP_TICK_CTRL_TICK_COUNT_EN.
module step_tick_ctrl #(
   parameter int DIV_W          = 32,
   parameter int DEFAULT_PERIOD = enigma_pkg::DEFAULT_PERIOD,
   parameter int BURST_W        = 8
) (
   input  logic                  clkin,
   input  logic                  rst,
   step_tick_ctrl_if.slave       cfg,
   input  logic                  run,
   input  logic                  step_req,
   input  logic                  burst_start,
   input  logic [BURST_W-1:0]    burst_len,
   output logic                  busy,
   output logic                  tick,
   output logic                  clkout,
   output enigma_pkg::tick_count_t tick_count
);
   import enigma_pkg::*;

   state_t             state_reg, state_next;
   logic [BURST_W-1:0] remaining_reg, remaining_next;
   logic [DIV_W-1:0]   period_reg;
   logic [DIV_W-1:0]   shadow_reg;
   logic               pending_reg;
   logic [DIV_W-1:0]   cfg_clamped;
   logic               cfg_accept;
   logic               expire;

   assign busy          = (state_reg != ST_IDLE);
   assign cfg.cfg_ready = ~pending_reg;
   assign cfg_accept    = cfg.cfg_valid && ~pending_reg;
   assign cfg_clamped   = (cfg.cfg_period == '0) ? DIV_W'(1) : cfg.cfg_period;

   tick_divider #(.DIV_W(DIV_W)) u_div (
      .clkin  (clkin),
      .rst    (rst),
      .en     (busy),
      .period (period_reg),
      .expire (expire),
      .tick   (tick),
      .clkout (clkout)
   );

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         remaining_reg <= '0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      case (state_reg)
         ST_IDLE: begin
            if (run) begin
               state_next = ST_RUN;
            end else if (burst_start && (burst_len != '0)) begin
               state_next     = ST_BURST;
               remaining_next = burst_len;
            end else if (step_req) begin
               state_next = ST_STEP;
            end
         end
         // Run is only sampled on a tick so the running period always completes.
         ST_RUN: begin
            if (expire && !run) state_next = ST_IDLE;
         end
         ST_STEP: begin
            if (expire) state_next = ST_IDLE;
         end
         ST_BURST: begin
            if (expire) begin
               remaining_next = remaining_reg - BURST_W'(1);
               if (remaining_reg == BURST_W'(1)) state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A pending shadow blocks new requests, so accept and apply never coincide.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         period_reg  <= DIV_W'(DEFAULT_PERIOD);
         shadow_reg  <= DIV_W'(DEFAULT_PERIOD);
         pending_reg <= 1'b0;
      end else if (cfg_accept) begin
         if (state_reg == ST_IDLE) begin
            period_reg <= cfg_clamped;
         end else begin
            shadow_reg  <= cfg_clamped;
            pending_reg <= 1'b1;
         end
      end else if (expire && pending_reg) begin
         period_reg  <= shadow_reg;
         pending_reg <= 1'b0;
      end
   end

`ifdef STEP_TICK_CTRL_TICK_COUNT_EN
   tick_count_t tick_count_reg;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         tick_count_reg <= '0;
      end else if (expire) begin
         tick_count_reg <= tick_count_reg + 16'd1;
      end
   end

   assign tick_count = tick_count_reg;
`else
   assign tick_count = '0;
`endif

endmodule

// File: tb/tb_step_tick_ctrl.sv
// Scoreboard bench for step_tick_ctrl: stimulus queues expected tick cycles, monitor checks them.
module tb_step_tick_ctrl;

   localparam int DIV_W   = 32;
   localparam int BURST_W = 8;

   typedef struct {
      int   cyc;
      logic clk;
   } exp_tick_t;

   logic               clkin = 1'b0;
   logic               rst;
   logic               run;
   logic               step_req;
   logic               burst_start;
   logic [BURST_W-1:0] burst_len;
   logic               busy;
   logic               tick;
   logic               clkout;
   logic [15:0]        tick_count;

   int        cyc = 0;
   int        n_checks = 0;
   int        n_errors = 0;
   logic      exp_clk = 1'b0;
   exp_tick_t exp_q[$];

   step_tick_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

   step_tick_ctrl #(.DIV_W(DIV_W), .DEFAULT_PERIOD(5000), .BURST_W(BURST_W)) dut (
      .clkin       (clkin),
      .rst         (rst),
      .cfg         (cfg_if),
      .run         (run),
      .step_req    (step_req),
      .burst_start (burst_start),
      .burst_len   (burst_len),
      .busy        (busy),
      .tick        (tick),
      .clkout      (clkout),
      .tick_count  (tick_count)
   );

   always #5 clkin = ~clkin;

   always @(posedge clkin) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_tick(input int c);
      exp_tick_t e;
      exp_clk = ~exp_clk;
      e.cyc   = c;
      e.clk   = exp_clk;
      exp_q.push_back(e);
   endtask

   task automatic nc(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic cfg_write(input logic [DIV_W-1:0] p);
      cfg_if.cfg_period = p;
      cfg_if.cfg_valid  = 1'b1;
   endtask

   // Monitor: every observed tick must match the oldest expected tick.
   always @(negedge clkin) begin
      if (!rst && tick) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
         end else begin
            exp_tick_t e;
            e = exp_q.pop_front();
            $display("tick cycle=%0d clkout=%0b expected_cycle=%0d", cyc, clkout, e.cyc);
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_clkout", {31'd0, clkout}, {31'd0, e.clk});
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      run = 1'b0;
      step_req = 1'b0;
      burst_start = 1'b0;
      burst_len = '0;
      cfg_if.cfg_period = '0;
      cfg_if.cfg_valid = 1'b0;
      nc(2);
      chk("reset_tick", {31'd0, tick}, 0);
      chk("reset_clkout", {31'd0, clkout}, 0);
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_cfg_ready", {31'd0, cfg_if.cfg_ready}, 1);
      chk("reset_tick_count", {16'd0, tick_count}, 0);
      rst = 1'b0;
      nc(1);

      // Reset mid-RUN at period 4
      n = cyc;
      cfg_write(4);
      nc(1);
      cfg_if.cfg_valid = 1'b0;
      run = 1'b1;
      push_tick(n + 6);
      push_tick(n + 10);
      nc(9);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_tick", {31'd0, tick}, 0);
      chk("async_rst_busy", {31'd0, busy}, 0);
      chk("async_rst_clkout", {31'd0, clkout}, 0);
      chk("async_rst_tick_count", {16'd0, tick_count}, 0);
      exp_clk = 1'b0;
      run = 1'b0;
      nc(1);
      rst = 1'b0;
      nc(1);

      // Single step at restored default period
      n = cyc;
      step_req = 1'b1;
      nc(1);
      step_req = 1'b0;
      push_tick(n + 5001);
      chk("step_busy", {31'd0, busy}, 1);
      nc(5000);
      nc(1);
      chk("step_idle", {31'd0, busy}, 0);

      // Free run at period 3, drop run mid-period
      n = cyc;
      cfg_write(3);
      nc(1);
      cfg_if.cfg_valid = 1'b0;
      run = 1'b1;
      push_tick(n + 5);
      push_tick(n + 8);
      push_tick(n + 11);
      nc(8);
      run = 1'b0;
      chk("run_busy_a", {31'd0, busy}, 1);
      nc(1);
      chk("run_busy_b", {31'd0, busy}, 1);
      nc(1);
      chk("run_stop_idle", {31'd0, busy}, 0);
      nc(4);

      // Burst of 5 at period 2, then zero-length burst
      n = cyc;
      cfg_write(2);
      nc(1);
      cfg_if.cfg_valid = 1'b0;
      burst_start = 1'b1;
      burst_len = 8'd5;
      nc(1);
      burst_start = 1'b0;
      for (int i = 0; i < 5; i++) push_tick(n + 4 + 2 * i);
      nc(9);
      chk("burst_busy", {31'd0, busy}, 1);
      nc(1);
      chk("burst_done", {31'd0, busy}, 0);
      nc(3);
      burst_start = 1'b1;
      burst_len = 8'd0;
      nc(1);
      burst_start = 1'b0;
      chk("burst_zero_busy", {31'd0, busy}, 0);
      nc(5);
      chk("burst_zero_still_idle", {31'd0, busy}, 0);

      // Priority: run wins over burst and step
      n = cyc;
      run = 1'b1;
      burst_start = 1'b1;
      burst_len = 8'd3;
      step_req = 1'b1;
      nc(1);
      burst_start = 1'b0;
      step_req = 1'b0;
      for (int i = 0; i < 4; i++) push_tick(n + 3 + 2 * i);
      nc(7);
      run = 1'b0;
      nc(1);
      chk("prio_idle", {31'd0, busy}, 0);
      nc(3);

      // Live reconfig: 4 -> 2 mid-period, then 0 (clamped to 1) accepted on a tick
      n = cyc;
      cfg_write(4);
      nc(1);
      cfg_if.cfg_valid = 1'b0;
      run = 1'b1;
      push_tick(n + 6);
      push_tick(n + 10);
      push_tick(n + 12);
      push_tick(n + 14);
      push_tick(n + 16);
      push_tick(n + 18);
      push_tick(n + 19);
      push_tick(n + 20);
      push_tick(n + 21);
      push_tick(n + 22);
      nc(6);
      chk("live_ready_before", {31'd0, cfg_if.cfg_ready}, 1);
      cfg_write(2);
      nc(1);
      cfg_if.cfg_valid = 1'b0;
      chk("live_ready_pending_a", {31'd0, cfg_if.cfg_ready}, 0);
      nc(1);
      chk("live_ready_pending_b", {31'd0, cfg_if.cfg_ready}, 0);
      nc(1);
      chk("live_ready_back", {31'd0, cfg_if.cfg_ready}, 1);
      nc(5);
      chk("zero_ready_before", {31'd0, cfg_if.cfg_ready}, 1);
      cfg_write(0);
      nc(1);
      cfg_if.cfg_valid = 1'b0;
      chk("zero_ready_pending_a", {31'd0, cfg_if.cfg_ready}, 0);
      nc(1);
      chk("zero_ready_pending_b", {31'd0, cfg_if.cfg_ready}, 0);
      nc(1);
      chk("zero_ready_back", {31'd0, cfg_if.cfg_ready}, 1);
      nc(3);
      run = 1'b0;
      nc(1);
      chk("live_idle", {31'd0, busy}, 0);
      nc(3);

`ifdef STEP_TICK_CTRL_TICK_COUNT_EN
      // Wrap check: 65537 ticks at period 1 leaves tick_count at 1
      nc(1);
      #1 rst = 1'b1;
      #1 chk("cnt_rst", {16'd0, tick_count}, 0);
      exp_clk = 1'b0;
      nc(1);
      rst = 1'b0;
      nc(1);
      n = cyc;
      cfg_write(1);
      nc(1);
      cfg_if.cfg_valid = 1'b0;
      run = 1'b1;
      for (int i = 0; i < 65537; i++) push_tick(n + 3 + i);
      nc(65537);
      run = 1'b0;
      nc(2);
      chk("cnt_busy", {31'd0, busy}, 0);
      chk("cnt_wrap", {16'd0, tick_count}, 1);
`else
      chk("tick_count_tied", {16'd0, tick_count}, 0);
`endif

      nc(2);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
